walk_vec_checker: RTL and testbench

Self-test responder for the five-input combinational decision block. It drives the block's five inputs with the team's fixed seven-vector walking-one sequence. It samples the single output `y` after a programmable settle time and compares each sample against an expected-response bitmap. It reports the captured responses, a mismatch count and pass/done status, replacing manual waveform inspection on silicon and FPGA builds.

---
 rtl/walk_vec_checker.sv | 145 ++++++++++++++
 tb/tb_walk_vec_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/walk_vec_checker.sv
// Walking-one self-test responder: steps a 5-bit stimulus through seven vectors.
// Each vector is held for SETTLE+1 cycles, y_in is sampled once per vector and the mismatches are counted.
module walk_vec_checker #(
    parameter int unsigned SETTLE = 2,
    parameter logic [6:0]  EXP    = 7'b0000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] vec_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_cnt,
    output logic [6:0] resp
);

    localparam int unsigned IDX_W      = 3;
    localparam int unsigned WCNT_W     = 4;
    localparam int unsigned VEC_W      = 5;
    localparam int unsigned NVEC       = 7;
    localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SETTLE_EFF - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NVEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [NVEC-1:0]     resp_q, resp_d;
    logic [2:0]          fail_q, fail_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    // Fixed walking-one stimulus table, {a,b,c,d,e}
    function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] i);
        logic [VEC_W-1:0] v;
        case (i)
            3'd0:    v = 5'b00000;
            3'd1:    v = 5'b10000;
            3'd2:    v = 5'b01000;
            3'd3:    v = 5'b00100;
            3'd4:    v = 5'b00010;
            3'd5:    v = 5'b00001;
            default: v = 5'b11111;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            vec_q   <= '0;
            resp_q  <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            vec_q   <= vec_d;
            resp_q  <= resp_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        vec_d   = vec_q;
        resp_d  = resp_q;
        fail_d  = fail_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    vec_d   = vec_of(IDX_W'(0));
                    resp_d  = '0;
                    fail_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (wcnt_q == WCNT_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                resp_d[idx_q] = y_in;
                if (y_in != EXP[idx_q]) begin
                    fail_d = fail_q + 3'd1;
                end
                if (idx_q != IDX_LAST) begin
                    idx_d   = idx_q + IDX_W'(1);
                    vec_d   = vec_of(idx_q + IDX_W'(1));
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    // Final vector: park stimulus at zero and publish the verdict together with done
                    vec_d   = '0;
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_d == 3'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign vec_out  = vec_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_cnt = fail_q;
    assign resp     = resp_q;

endmodule

// File: tb/tb_walk_vec_checker.sv
// Self-checking bench for walk_vec_checker: two instances (SETTLE=2 and SETTLE=1).
// Results are compared with a per-cycle reference model derived from the vector table.
module tb_walk_vec_checker;

    localparam int unsigned S0 = 2;
    localparam int unsigned S1 = 1;
    localparam logic [6:0]  E0 = 7'b1111110;
    localparam logic [6:0]  E1 = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       y0, y1;
    logic [4:0] vec0, vec1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] fail0, fail1;
    logic [6:0] resp0, resp1;

    int         mode;
    logic [6:0] rpat;
    logic       ytog;
    int         sel;

    logic [4:0] o_vec;
    logic       o_busy, o_done, o_pass;
    logic [2:0] o_fail;
    logic [6:0] o_resp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    walk_vec_checker #(.SETTLE(S0), .EXP(E0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_cnt(fail0), .resp(resp0)
    );

    walk_vec_checker #(.SETTLE(S1), .EXP(E1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fail1), .resp(resp1)
    );

    // Vector k of the walking sequence: zero, a single one walking from a down to e, then all ones
    function automatic logic [4:0] vexp(input int k);
        if (k == 0) return 5'b00000;
        if (k == 6) return 5'b11111;
        return 5'b10000 >> (k - 1);
    endfunction

    function automatic int vidx(input logic [4:0] v);
        if (v == 5'b11111) return 6;
        for (int b = 0; b < 5; b++) if (v[b]) return 5 - b;
        return 0;
    endfunction

    // Behaviour of the block under test for each stimulus mode
    function automatic logic yfun(input int m, input logic [6:0] rp, input logic t, input logic [4:0] v);
        case (m)
            0:       return |v;
            1:       return &v;
            2:       return 1'b1;
            3:       return rp[vidx(v)];
            default: return t;
        endcase
    endfunction

    always_comb y0 = yfun(mode, rpat, ytog, vec0);
    always_comb y1 = yfun(mode, rpat, ytog, vec1);

    always_comb begin
        if (sel == 0) begin
            o_vec = vec0; o_busy = busy0; o_done = done0; o_pass = pass0; o_fail = fail0; o_resp = resp0;
        end else begin
            o_vec = vec1; o_busy = busy1; o_done = done1; o_pass = pass1; o_fail = fail1; o_resp = resp1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete run on the selected instance, checked every cycle against the model
    task automatic run(input int s, input int m, input logic [6:0] exp, input bit repulse);
        logic [6:0] er;
        logic [6:0] mask;
        int         cyc;
        int         per;
        int         nf;
        per = s + 1;
        for (int k = 0; k < 7; k++) er[k] = yfun(m, rpat, 1'b0, vexp(k));
        nf = $countones(er ^ exp);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        chk("start_done_low", 32'(o_done), 32'(0));
        while (!o_done && cyc < 200) begin
            if (cyc < 7 * per) begin
                mask = 7'((8'd1 << (cyc / per)) - 8'd1);
                chk("vec", 32'(o_vec), 32'(vexp(cyc / per)));
                chk("busy", 32'(o_busy), 32'(1));
                chk("resp_partial", 32'(o_resp), 32'(er & mask));
                chk("fail_partial", 32'(o_fail), 32'($countones((er ^ exp) & mask)));
            end
            start = (repulse && (cyc == 3 || cyc == 9)) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", 32'(cyc), 32'(7 * per));
        chk("done", 32'(o_done), 32'(1));
        chk("busy_end", 32'(o_busy), 32'(0));
        chk("pass", 32'(o_pass), 32'(nf == 0));
        chk("resp", 32'(o_resp), 32'(er));
        chk("fail_cnt", 32'(o_fail), 32'(nf));
        chk("vec_end", 32'(o_vec), 32'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({vec0, busy0, done0, pass0, fail0, resp0}), 32'(0));
        chk({tag, "_1"}, 32'({vec1, busy1, done1, pass1, fail1, resp1}), 32'(0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 4;
        rpat  = '0;
        ytog  = 1'b0;
        sel   = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle with toggling response: nothing may move
        for (int i = 0; i < 50; i++) begin
            ytog = 1'($urandom);
            @(negedge clk);
            chk_zero("idle");
        end

        mode = 0;
        run(S0, 0, E0, 1'b0);
        mode = 1;
        run(S0, 1, E0, 1'b0);
        mode = 0;
        run(S0, 0, E0, 1'b1);
        run(S0, 0, E0, 1'b0);
        mode = 1;
        run(S0, 1, E0, 1'b1);

        mode = 3;
        for (int i = 0; i < 4; i++) begin
            rpat = 7'($urandom);
            run(S0, 3, E0, 1'($urandom));
        end

        repeat (30) @(negedge clk);
        sel  = 1;
        mode = 2;
        run(S1, 2, E1, 1'b0);
        mode = 3;
        for (int i = 0; i < 3; i++) begin
            repeat (30) @(negedge clk);
            rpat = 7'($urandom);
            run(S1, 3, E1, 1'($urandom));
        end

        // Asynchronous reset mid-vector
        repeat (30) @(negedge clk);
        sel  = 0;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", 32'(busy0), 32'(1));
        #1 rst = 1'b1;
        #1 chk_zero("async_reset");
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("post_reset");
        run(S0, 0, E0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
